// File: rtl/pc_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, imem request FSM, one-entry hold buffer, IF/ID register.
// Optional misaligned-redirect pulse enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_pc;

    assign redirect  = branch_taken | jump_en;
    // branch_taken wins when both redirects fire
    assign redir_raw = branch_taken ? branch_target : jump_target;
    assign redir_pc  = redir_raw & 32'hFFFF_FFFC;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: BOOT always lasts one cycle; redirects force FETCH
    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (imem_ready && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // Request is only issued while in FETCH
    always_comb begin
        imem_req = 1'b0;
        if (state == FETCH) begin
            imem_req = 1'b1;
        end
    end

    // PC, hold buffer and IF/ID register updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            hold_instr     <= 32'd0;
            hold_pc4       <= 32'd0;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (redirect) begin
            pc          <= redir_pc;
            if_id_valid <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready && !stall) begin
                        if_id_instr    <= imem_rdata;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_plus4;
                    end else if (imem_ready) begin
                        hold_instr <= imem_rdata;
                        hold_pc4   <= pc_plus4;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_instr    <= hold_instr;
                        if_id_pc_plus4 <= hold_pc4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_plus4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    // One-cycle flag for a redirect whose target was not word aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (redir_raw[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed, table-driven bench for pc_fetch_stage.
// Each row: inputs for one cycle, expected outputs after that edge.
module tb_pc_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misalign_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .pc_plus4       (pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .misalign_err   (misalign_err)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] ipc4;
        logic        mis;
    } vec_t;

    vec_t vt[$];

    task automatic add(
        input logic rdy, input logic [31:0] rdata, input logic stl,
        input logic br, input logic [31:0] bt,
        input logic jmp, input logic [31:0] jt,
        input logic req, input logic [31:0] addr, input logic vld,
        input logic [31:0] instr, input logic [31:0] ipc4, input logic mis
    );
        vec_t v;
        v.rdy = rdy; v.rdata = rdata; v.stl = stl;
        v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.req = req; v.addr = addr; v.vld = vld;
        v.instr = instr; v.ipc4 = ipc4; v.mis = mis;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        imem_ready    = v.rdy;
        imem_rdata    = v.rdata;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump_en       = v.jmp;
        jump_target   = v.jt;
    endtask

    task automatic idle();
        imem_ready   = 1'b0;
        imem_rdata   = 32'd0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump_en      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rdy rdata stl br bt jmp jt | req addr vld instr ipc4 mis
        add(1, 32'h0, 0, 0, 0, 0, 0,
            1, RPC, 0, 32'h0, 32'h0, 0);
        add(1, 32'h2008_0005, 0, 0, 0, 0, 0,
            1, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004, 0);
        add(1, 32'h1111_1111, 0, 0, 0, 0, 0,
            1, 32'h0040_0008, 1, 32'h1111_1111, 32'h0040_0008, 0);
        add(0, 32'h0, 0, 0, 0, 0, 0,
            1, 32'h0040_0008, 0, 32'h1111_1111, 32'h0040_0008, 0);
        add(1, 32'h2222_2222, 0, 0, 0, 0, 0,
            1, 32'h0040_000C, 1, 32'h2222_2222, 32'h0040_000C, 0);
        add(1, 32'h3333_3333, 0, 1, 32'h0040_0020, 0, 0,
            1, 32'h0040_0020, 0, 32'h2222_2222, 32'h0040_000C, 0);
        add(1, 32'hAAAA_0001, 1, 0, 0, 0, 0,
            0, 32'h0040_0020, 0, 32'h2222_2222, 32'h0040_000C, 0);
        add(0, 32'h0, 1, 0, 0, 0, 0,
            0, 32'h0040_0020, 0, 32'h2222_2222, 32'h0040_000C, 0);
        add(1, 32'hBBBB_BBBB, 0, 0, 0, 0, 0,
            1, 32'h0040_0024, 1, 32'hAAAA_0001, 32'h0040_0024, 0);
        add(0, 32'h0, 1, 0, 0, 0, 0,
            1, 32'h0040_0024, 1, 32'hAAAA_0001, 32'h0040_0024, 0);
        add(0, 32'h0, 0, 0, 0, 0, 0,
            1, 32'h0040_0024, 0, 32'hAAAA_0001, 32'h0040_0024, 0);
        add(1, 32'hDEAD_BEEF, 0, 1, 32'h100, 1, 32'h200,
            1, 32'h100, 0, 32'hAAAA_0001, 32'h0040_0024, 0);
        add(0, 32'h0, 1, 0, 0, 1, 32'h102,
            1, 32'h100, 0, 32'hAAAA_0001, 32'h0040_0024, MIS);
        add(1, 32'h4444_4444, 0, 0, 0, 0, 0,
            1, 32'h104, 1, 32'h4444_4444, 32'h104, 0);
        add(0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFC,
            1, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'h104, 0);
        add(1, 32'h5555_5555, 0, 0, 0, 0, 0,
            1, 32'h0, 1, 32'h5555_5555, 32'h0, 0);
        add(1, 32'h6666_6666, 1, 0, 0, 0, 0,
            0, 32'h0, 1, 32'h5555_5555, 32'h0, 0);
        add(0, 32'h0, 1, 1, 32'h200, 0, 0,
            1, 32'h200, 0, 32'h5555_5555, 32'h0, 0);
        add(1, 32'h7777_7777, 0, 0, 0, 0, 0,
            1, 32'h204, 1, 32'h7777_7777, 32'h204, 0);
        add(1, 32'h9999_9999, 0, 1, 32'h203, 0, 0,
            1, 32'h200, 0, 32'h7777_7777, 32'h204, MIS);
        add(0, 32'h0, 0, 0, 0, 0, 0,
            1, 32'h200, 0, 32'h7777_7777, 32'h204, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_pc_plus4", pc_plus4, RPC + 32'd4);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_ipc4", if_id_pc_plus4, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vt[i].addr + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vt[i].vld});
            chk($sformatf("v%0d_instr", i), if_id_instr, vt[i].instr);
            chk($sformatf("v%0d_ipc4", i), if_id_pc_plus4, vt[i].ipc4);
            chk($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, vt[i].mis});
        end

        // Asynchronous reset in the middle of a cycle
        idle();
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("pre_arst_valid", {31'd0, if_id_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", imem_addr, RPC);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr, 32'd0);
        chk("arst_ipc4", if_id_pc_plus4, 32'd0);

        // Redirect during BOOT: target loads, BOOT still one cycle
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        jump_en = 1'b1;
        jump_target = 32'h0000_0300;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("boot_redir_req", {31'd0, imem_req}, 32'd1);
        chk("boot_redir_addr", imem_addr, 32'h0000_0300);
        chk("boot_redir_valid", {31'd0, if_id_valid}, 32'd0);
        idle();
        imem_ready = 1'b1;
        imem_rdata = 32'h8888_8888;
        @(posedge clk);
        #1;
        chk("boot_first_instr", if_id_instr, 32'h8888_8888);
        chk("boot_first_ipc4", if_id_pc_plus4, 32'h0000_0304);
        chk("boot_first_valid", {31'd0, if_id_valid}, 32'd1);
        chk("boot_next_addr", imem_addr, 32'h0000_0304);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
